// File: rtl/mt_register_file_v2_pkg.sv
// Shared types for the multi-thread register file and its clear engine.
package mt_register_file_v2_pkg;

    // Hardware thread contexts in this core; the thread timer sizes itself from this too.
    localparam int unsigned NUM_HW_THREADS = 4;
    localparam int unsigned THREAD_ID_W    = $clog2(NUM_HW_THREADS);

    typedef logic [THREAD_ID_W-1:0] thread_id_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        CLEAR
    } regfile_state_t;

endpackage

// File: rtl/mt_register_file_v2_clear_fsm.sv
// Clear engine: post-reset sweep of every entry, per-thread clear on request, and
// arbitration of the single storage write port between writeback and zero-writes.
module regfile_clear_fsm
    import mt_register_file_v2_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned NUM_THREADS     = 4,
    parameter int unsigned REGS_PER_THREAD = 32,
    localparam int unsigned TID_W = $clog2(NUM_THREADS),
    localparam int unsigned RA_W  = $clog2(REGS_PER_THREAD),
    localparam int unsigned IDX_W = TID_W + RA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [TID_W-1:0]       wr_thread_id,
    input  logic [RA_W-1:0]        rd_addr,
    input  logic [XLEN-1:0]        new_data,
    input  logic                   clear_valid,
    input  logic [TID_W-1:0]       clear_thread_id,
    output logic                   port_we,
    output logic [IDX_W-1:0]       port_waddr,
    output logic [XLEN-1:0]        port_wdata,
    output logic                   clear_ready,
    output logic [NUM_THREADS-1:0] clear_busy_thread,
    output logic                   clear_done,
    output logic                   init_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_THREADS * REGS_PER_THREAD - 1);
    localparam logic [RA_W-1:0]  LAST_REG = RA_W'(REGS_PER_THREAD - 1);

    regfile_state_t   state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [TID_W-1:0] tid_q, tid_d;
    logic             done_q, done_d;
    logic             init_done_q, init_done_d;
    logic             ext_valid;

    // x0 writes never reach storage, so they do not compete for the port either.
    assign ext_valid = wr_en && (rd_addr != '0);

    // State, counter and sticky/pulse flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            tid_q       <= '0;
            done_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tid_q       <= tid_d;
            done_q      <= done_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state, write-port arbitration and handshake outputs.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        tid_d             = tid_q;
        done_d            = 1'b0;
        init_done_d       = init_done_q;
        port_we           = 1'b0;
        port_waddr        = '0;
        port_wdata        = '0;
        clear_ready       = 1'b0;
        clear_busy_thread = '0;

        unique case (state_q)
            INIT: begin
                // Writeback is ignored; the sweep owns the port every cycle.
                clear_busy_thread = '1;
                port_we           = 1'b1;
                port_waddr        = cnt_q;
                if (cnt_q == LAST_IDX) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    done_d      = 1'b1;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                clear_ready = 1'b1;
                if (ext_valid) begin
                    port_we    = 1'b1;
                    port_waddr = {wr_thread_id, rd_addr};
                    port_wdata = new_data;
                end
                if (clear_valid) begin
                    tid_d   = clear_thread_id;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clear_busy_thread = NUM_THREADS'(1) << tid_q;
                if (ext_valid && (wr_thread_id != tid_q)) begin
                    // Live thread wins the port; the clear stalls one cycle.
                    port_we    = 1'b1;
                    port_waddr = {wr_thread_id, rd_addr};
                    port_wdata = new_data;
                end else begin
                    // Writes to the dying thread are dropped.
                    port_we    = 1'b1;
                    port_waddr = {tid_q, cnt_q[RA_W-1:0]};
                    if (cnt_q[RA_W-1:0] == LAST_REG) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign clear_done = done_q;
    assign init_done  = init_done_q;

endmodule

// File: rtl/mt_register_file_v2.sv
// Multi-thread integer register file: one write port, NUM_READ_PORTS registered read
// ports, x0 hardwired to zero, background clear engine.
// Optional macro REGFILE_BYPASS_EN: write-first forwarding of same-cycle writes to reads.
module mt_register_file_v2
    import mt_register_file_v2_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned NUM_THREADS     = NUM_HW_THREADS,
    parameter int unsigned REGS_PER_THREAD = 32,
    parameter int unsigned NUM_READ_PORTS  = 2,
    localparam int unsigned TID_W = $clog2(NUM_THREADS),
    localparam int unsigned RA_W  = $clog2(REGS_PER_THREAD)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_en,
    input  logic [TID_W-1:0]                         wr_thread_id,
    input  logic [RA_W-1:0]                          rd_addr,
    input  logic [XLEN-1:0]                          new_data,
    input  logic [TID_W-1:0]                         rs_thread_id,
    input  logic [NUM_READ_PORTS-1:0]                rs_en,
    input  logic [NUM_READ_PORTS-1:0][RA_W-1:0]      rs_addr,
    output logic [NUM_READ_PORTS-1:0][XLEN-1:0]      rs_data,
    input  logic                                     clear_valid,
    input  logic [TID_W-1:0]                         clear_thread_id,
    output logic                                     clear_ready,
    output logic [NUM_THREADS-1:0]                   clear_busy_thread,
    output logic                                     clear_done,
    output logic                                     init_done
);

    localparam int unsigned DEPTH = NUM_THREADS * REGS_PER_THREAD;
    localparam int unsigned IDX_W = TID_W + RA_W;

    logic             port_we;
    logic [IDX_W-1:0] port_waddr;
    logic [XLEN-1:0]  port_wdata;

    regfile_clear_fsm #(
        .XLEN            (XLEN),
        .NUM_THREADS     (NUM_THREADS),
        .REGS_PER_THREAD (REGS_PER_THREAD)
    ) u_clear_fsm (
        .clk               (clk),
        .rst               (rst),
        .wr_en             (wr_en),
        .wr_thread_id      (wr_thread_id),
        .rd_addr           (rd_addr),
        .new_data          (new_data),
        .clear_valid       (clear_valid),
        .clear_thread_id   (clear_thread_id),
        .port_we           (port_we),
        .port_waddr        (port_waddr),
        .port_wdata        (port_wdata),
        .clear_ready       (clear_ready),
        .clear_busy_thread (clear_busy_thread),
        .clear_done        (clear_done),
        .init_done         (init_done)
    );

    // One storage copy per read port, all written identically.
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        logic [XLEN-1:0]  mem [DEPTH];
        logic [IDX_W-1:0] raddr;
        logic [XLEN-1:0]  rd_val;
        logic [XLEN-1:0]  rdata_q;

        assign raddr = {rs_thread_id, rs_addr[p]};

        // Storage write, no reset: contents are zeroed by the init sweep.
        always_ff @(posedge clk) begin
            if (port_we) begin
                mem[port_waddr] <= port_wdata;
            end
        end

        // Read value before registering: bypass, then thread-busy and x0 masking.
        always_comb begin
            rd_val = mem[raddr];
`ifdef REGFILE_BYPASS_EN
            if (port_we && (port_waddr == raddr)) begin
                rd_val = port_wdata;
            end
`endif
            if (clear_busy_thread[rs_thread_id] || (rs_addr[p] == '0)) begin
                rd_val = '0;
            end
        end

        // Registered read data; holds when the port is not enabled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (rs_en[p]) begin
                rdata_q <= rd_val;
            end
        end

        assign rs_data[p] = rdata_q;
    end

endmodule

// File: doc/mt_register_file_v2.md
Name: mt_register_file_v2

Overview:
- Parametrised multi-hardware-thread integer register file; successor to the fixed 4-thread, 2-read-port file.
- Thread count, register count and read-port count are parameters. x0 is hardwired to zero per thread.
- A sequential clear engine zeroes all entries after reset, and zeroes any single thread on request (thread spawn/kill).
- Sits between decode/issue (read ports) and writeback (single write port).

Parameters:
- XLEN, 32, data width.
- NUM_THREADS, 4, hardware thread contexts; power of two, >=2.
- REGS_PER_THREAD, 32, architectural registers per thread; power of two.
- NUM_READ_PORTS, 2, synchronous read ports, 1..4.
- Derived: TID_W = $clog2(NUM_THREADS), RA_W = $clog2(REGS_PER_THREAD), DEPTH = NUM_THREADS*REGS_PER_THREAD.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  writeback write strobe.
- wr_thread_id  in  TID_W  writeback thread.
- rd_addr  in  RA_W  destination register.
- new_data  in  XLEN  writeback data.
- rs_thread_id  in  TID_W  thread for all read ports this cycle.
- rs_en  in  NUM_READ_PORTS  per-port read enable.
- rs_addr  in  NUM_READ_PORTS x RA_W  per-port source register.
- rs_data  out  NUM_READ_PORTS x XLEN  per-port read data, registered.
- clear_valid  in  1  request to zero one thread.
- clear_thread_id  in  TID_W  thread to clear; held while clear_valid is high.
- clear_ready  out  1  engine idle; request accepted when valid & ready.
- clear_busy_thread  out  NUM_THREADS  one-hot: thread currently being cleared (all ones during INIT).
- clear_done  out  1  one-cycle pulse when a clear or the init sweep completes.
- init_done  out  1  high once the post-reset sweep has finished.

Behaviour:
- Reset (async, rst=1):
  - All rs_data = 0, clear_done = 0, init_done = 0, clear_ready = 0, clear_busy_thread = all ones.
  - FSM enters INIT with the sweep counter at 0. Storage is not reset directly.
- FSM states:
  - INIT: the counter walks 0..DEPTH-1 writing zero, one entry per cycle. At DEPTH-1, go to IDLE, pulse clear_done, set init_done = 1 (sticky until the next rst).
  - IDLE: clear_ready = 1. On clear_valid, latch the thread id, zero the counter, go to CLEAR.
  - CLEAR: writes zero to {tid, cnt}, incrementing cnt. At REGS_PER_THREAD-1, return to IDLE and pulse clear_done. clear_ready = 0 throughout.
- Write-port arbitration:
  - In INIT, external wr_en is ignored.
  - In CLEAR, an external write to a different thread wins the port; the clear counter holds that cycle.
  - In CLEAR, an external write to the thread being cleared is dropped and the counter advances.
- x0: writes with rd_addr==0 are dropped; reads of rs_addr==0 return 0 regardless of storage.
- Reads:
  - 1-cycle latency: rs_data[p] updates on the clk edge after rs_en[p]=1; it holds its value when rs_en[p]=0.
  - Reads return 0 during INIT, and when rs_thread_id matches the thread being cleared in CLEAR.
- Same-cycle write and read of the same {thread, reg}: governed by REGFILE_BYPASS_EN.
- Storage: block-RAM style, indexed {thread, reg}. Read ports are implemented by replication per port, each copy written identically.
- rst mid-CLEAR: abort immediately, re-enter INIT (full sweep).
- clear_valid during INIT or CLEAR: not accepted; the requester holds until clear_ready.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first. A same-cycle, non-dropped write to the read {thread, addr} forwards new_data into rs_data.
- Undefined: read-first. rs_data returns the pre-write contents; the pipeline handles the hazard.

Decomposition:
- Shared package cpu_types gets:
  - regfile_state_t enum {INIT, IDLE, CLEAR};
  - typedef thread_id_t logic [TID_W-1:0];
  - constant NUM_HW_THREADS, reused by the thread timer.
- rs_addr_t stays in riscv_types.
- One sub-module, regfile_clear_fsm: owns the counter, state, arbitration and done/ready outputs, and emits the internal zero-write port.

Test Plan:
- Reset, then idle for DEPTH cycles (128 with defaults) -> init_done rises on cycle 128 with a clear_done pulse the same cycle; reading t2 x5 returns 0.
- Write t1 x7=0xDEADBEEF, next cycle read rs_addr[0]=7 on t1 and t0 -> port 0 shows 0xDEADBEEF for t1 and 0 for t0, one cycle after rs_en.
- Write x0=0x1234 on t3, then read x0 -> 0.
- Same-cycle write t0 x3=0xA5A5 and read t0 x3 (old value 0x1) -> 0xA5A5 with bypass, 0x1 without.
- Fill t2 x1..x31 with nonzero values, then clear t2 while writing t0 x4=0x55 at cycle 5 of the clear -> clear_done after 33 cycles (32 + 1 stall); t2 reads all 0; t0 x4 = 0x55; a write to t2 mid-clear is dropped.
- Assert rst at cycle 10 of a CLEAR -> clear_ready = 0, re-sweep, init_done after 128 cycles, all rs_data reset to 0.
